// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Holds the sequencer state encoding, requester indices and the full-word byte enable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/byte_merge.sv
// Per-byte-lane select between an existing memory word and new write data.
// Lanes whose byte enable is set take the new data; all other lanes keep the old data.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-ported, full-word data memory.
// Reads take two cycles; partial-word writes become a two-cycle read-modify-write sequence.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_write,
    input  logic [31:0] mem_readdata
);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic        req0, req1, win;
    logic [31:0] win_addr, win_data;
    logic [3:0]  win_be;
    logic        win_write;
    logic        done, rd_done;
    logic [31:0] merged;

    // Byte-offset address bits select nothing in a word-wide memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_address[1:0], m1_address[1:0]};

    byte_merge u_byte_merge (
        .old_word (mem_readdata),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        if (req0 && req1) begin
            win = (RR_ENABLE != 0) ? ~last_grant_q : PORT0;
        end else begin
            win = req0 ? PORT0 : PORT1;
        end
        win_addr  = (win == PORT0) ? m0_address    : m1_address;
        win_data  = (win == PORT0) ? m0_writedata  : m1_writedata;
        win_be    = (win == PORT0) ? m0_byteenable : m1_byteenable;
        win_write = (win == PORT0) ? m0_write      : m1_write;
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        mem_address   = addr_q;
        mem_writedata = wdata_q;
        mem_write     = 1'b0;
        done          = 1'b0;
        rd_done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    last_grant_d = win;
                    owner_d      = win;
                    addr_d       = {win_addr[31:2], 2'b00};
                    wdata_d      = win_data;
                    be_d         = win_be;
                    mem_address  = {win_addr[31:2], 2'b00};
                    if (win_write && win_be == BE_FULL) begin
                        mem_writedata = win_data;
                        mem_write     = 1'b1;
                        done          = 1'b1;
                    end else if (win_write && win_be == 4'b0000) begin
                        done = 1'b1;
                    end else begin
                        state_d = win_write ? RMW_WAIT : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                done    = 1'b1;
                rd_done = 1'b1;
                state_d = IDLE;
            end
            RMW_WAIT: begin
                mem_writedata = merged;
                mem_write     = 1'b1;
                done          = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset abandons whatever is in flight, including a pending RMW write-back.
        if (reset) begin
            mem_address = 32'h0;
            mem_write   = 1'b0;
            done        = 1'b0;
            rd_done     = 1'b0;
        end
    end

    assign m0_waitrequest = ~(done && owner_d == PORT0);
    assign m1_waitrequest = ~(done && owner_d == PORT1);
    assign m0_readdata    = (rd_done && owner_q == PORT0) ? mem_readdata : 32'h0;
    assign m1_readdata    = (rd_done && owner_q == PORT1) ? mem_readdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            owner_q      <= PORT0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'b0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference of arbitration, latency and memory contents.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_write;

    data_mem_arbiter #(.RR_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_write(mem_write), .mem_readdata(mem_readdata)
    );

    // Fixed-priority instance with its own trivial memory.
    logic        f0_read, f1_read, f0_waitrequest, f1_waitrequest, f_mem_write;
    logic [31:0] f0_address, f1_address, f0_readdata, f1_readdata;
    logic [31:0] f_mem_address, f_mem_writedata, f_mem_readdata;

    data_mem_arbiter #(.RR_ENABLE(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_read(f0_read), .m0_write(1'b0), .m0_address(f0_address),
        .m0_writedata(32'h0), .m0_byteenable(4'b1111),
        .m0_waitrequest(f0_waitrequest), .m0_readdata(f0_readdata),
        .m1_read(f1_read), .m1_write(1'b0), .m1_address(f1_address),
        .m1_writedata(32'h0), .m1_byteenable(4'b1111),
        .m1_waitrequest(f1_waitrequest), .m1_readdata(f1_readdata),
        .mem_address(f_mem_address), .mem_writedata(f_mem_writedata),
        .mem_write(f_mem_write), .mem_readdata(f_mem_readdata)
    );

    always @(posedge clk) f_mem_readdata <= f_mem_address ^ 32'hA5A5_0000;

    function automatic logic [31:0] init_word(int i);
        if (i == 8) return 32'h1122_3344;
        return 32'h0F1E_2D3C + 32'h0101_0101 * i;
    endfunction

    // Harness memory: 16 words, registered read, write on posedge.
    logic [31:0] hmem [16];
    logic        preload_en;
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 16; i++) hmem[i] <= init_word(i);
        end else if (mem_write) begin
            hmem[mem_address[5:2]] <= mem_writedata;
        end
        mem_readdata <= hmem[mem_address[5:2]];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_ref(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Requester state: each request is held until the reference says it completed.
    logic        q_act [2], q_rd [2], q_wr [2];
    logic [31:0] q_addr [2], q_data [2];
    logic [3:0]  q_be [2];
    int          mode [2];  // 0 one-shot, 1 repeat, 2 random

    // Reference: memory image, busy flag and the latched transaction.
    logic [31:0] ref_mem [16];
    logic        m_busy, m_lastg, m_wr;
    int          m_port;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_be;

    logic        obs_w [2];
    logic [31:0] obs_r [2];
    logic        obs_mw;
    logic [31:0] obs_wd;
    int          obs_log [$];
    int          mw_pulses;

    task automatic new_rand(int p);
        int op;
        op = $urandom_range(0, 3);
        q_act[p]  = 1'b1;
        q_rd[p]   = (op != 2);
        q_wr[p]   = (op >= 2);
        q_addr[p] = $urandom;
        q_data[p] = $urandom;
        case ($urandom_range(0, 3))
            0:       q_be[p] = 4'b1111;
            1:       q_be[p] = 4'b0000;
            default: q_be[p] = 4'($urandom_range(0, 15));
        endcase
    endtask

    task automatic set_req(int p, logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                           logic [3:0] be);
        mode[p] = 0; q_act[p] = 1'b1; q_rd[p] = rd; q_wr[p] = wr;
        q_addr[p] = a; q_data[p] = d; q_be[p] = be;
    endtask

    task automatic tick();
        logic        e_w [2];
        logic [31:0] e_r [2];
        logic        e_mw, chk_ma, r0, r1;
        logic [31:0] e_wd, e_ma;
        int          done, win, idx;
        // Owner's inputs are scrambled while it waits: the DUT must use latched values.
        m0_read       = q_act[0] & q_rd[0];
        m0_write      = q_act[0] & q_wr[0];
        m0_address    = (m_busy && m_port == 0) ? $urandom : q_addr[0];
        m0_writedata  = (m_busy && m_port == 0) ? $urandom : q_data[0];
        m0_byteenable = (m_busy && m_port == 0) ? 4'($urandom) : q_be[0];
        m1_read       = q_act[1] & q_rd[1];
        m1_write      = q_act[1] & q_wr[1];
        m1_address    = (m_busy && m_port == 1) ? $urandom : q_addr[1];
        m1_writedata  = (m_busy && m_port == 1) ? $urandom : q_data[1];
        m1_byteenable = (m_busy && m_port == 1) ? 4'($urandom) : q_be[1];
        @(negedge clk);
        e_w[0] = 1'b1; e_w[1] = 1'b1; e_r[0] = 32'h0; e_r[1] = 32'h0;
        e_mw = 1'b0; chk_ma = 1'b0; e_wd = 32'h0; e_ma = 32'h0; done = -1;
        if (reset) begin
            m_busy = 1'b0; m_lastg = 1'b1; chk_ma = 1'b1;
        end else if (m_busy) begin
            done = m_port; m_busy = 1'b0; e_w[m_port] = 1'b0; idx = int'(m_addr[5:2]);
            if (!m_wr) begin
                e_r[m_port] = ref_mem[idx];
            end else begin
                e_mw = 1'b1; chk_ma = 1'b1; e_ma = {m_addr[31:2], 2'b00};
                e_wd = merge_ref(ref_mem[idx], m_data, m_be); ref_mem[idx] = e_wd;
            end
        end else begin
            r0 = q_act[0] & (q_rd[0] | q_wr[0]);
            r1 = q_act[1] & (q_rd[1] | q_wr[1]);
            if (r0 || r1) begin
                if (r0 && r1) win = (m_lastg == 1'b0) ? 1 : 0;
                else          win = r0 ? 0 : 1;
                m_lastg = win[0];
                idx = int'(q_addr[win][5:2]);
                if (q_wr[win] && q_be[win] == 4'b1111) begin
                    done = win; e_w[win] = 1'b0; e_mw = 1'b1; chk_ma = 1'b1;
                    e_ma = {q_addr[win][31:2], 2'b00}; e_wd = q_data[win];
                    ref_mem[idx] = e_wd;
                end else if (q_wr[win] && q_be[win] == 4'b0000) begin
                    done = win; e_w[win] = 1'b0;
                end else begin
                    m_busy = 1'b1; m_port = win; m_wr = q_wr[win];
                    m_addr = q_addr[win]; m_data = q_data[win]; m_be = q_be[win];
                end
            end
        end
        obs_w[0] = m0_waitrequest; obs_w[1] = m1_waitrequest;
        obs_r[0] = m0_readdata;    obs_r[1] = m1_readdata;
        obs_mw = mem_write; obs_wd = mem_writedata;
        if (mem_write) mw_pulses++;
        if (!m0_waitrequest) obs_log.push_back(0);
        if (!m1_waitrequest) obs_log.push_back(1);
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(e_w[0]));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(e_w[1]));
        chk("m0_readdata", m0_readdata, e_r[0]);
        chk("m1_readdata", m1_readdata, e_r[1]);
        chk("mem_write", 32'(mem_write), 32'(e_mw));
        if (chk_ma) chk("mem_address", mem_address, e_ma);
        if (e_mw) chk("mem_writedata", mem_writedata, e_wd);
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            if (done == p && mode[p] != 1) q_act[p] = 1'b0;
            if (mode[p] == 2 && !q_act[p] && $urandom_range(0, 3) != 0) new_rand(p);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    logic [31:0] saved;
    int          guard;

    initial begin
        reset = 1'b1; preload_en = 1'b1; m_busy = 1'b0; m_lastg = 1'b1; m_port = 0;
        m_wr = 1'b0; m_addr = 0; m_data = 0; m_be = 0; mw_pulses = 0;
        f0_read = 1'b0; f1_read = 1'b0; f0_address = 32'h40; f1_address = 32'h80;
        for (int p = 0; p < 2; p++) begin
            q_act[p] = 1'b0; q_rd[p] = 1'b0; q_wr[p] = 1'b0; mode[p] = 0;
            q_addr[p] = 0; q_data[p] = 0; q_be[p] = 0;
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        tick(); tick();
        preload_en = 1'b0; reset = 1'b0;

        // Full write then read from m1.
        set_req(1, 1'b0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111);
        tick();
        chk("fw_m1_wait_c0", 32'(obs_w[1]), 32'd0);
        chk("fw_mem_write", 32'(obs_mw), 32'd1);
        set_req(1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'b1111);
        tick();
        chk("rd_m1_wait_c0", 32'(obs_w[1]), 32'd1);
        tick();
        chk("rd_m1_wait_c1", 32'(obs_w[1]), 32'd0);
        chk("rd_m1_data", obs_r[1], 32'hDEAD_BEEF);

        // Partial write to a preloaded word.
        set_req(1, 1'b0, 1'b1, 32'h1000_0020, 32'hAABB_CCDD, 4'b0101);
        mw_pulses = 0;
        tick();
        chk("pw_wait_c0", 32'(obs_w[1]), 32'd1);
        tick();
        chk("pw_wait_c1", 32'(obs_w[1]), 32'd0);
        chk("pw_word", hmem[8], 32'h11BB_33DD);
        tick();
        chk("pw_pulses", 32'(mw_pulses), 32'd1);

        // Round-robin with both ports reading continuously after reset.
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'b1111); mode[0] = 1;
        set_req(1, 1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'b1111); mode[1] = 1;
        obs_log.delete();
        for (int i = 0; i < 8; i++) tick();
        mode[0] = 0; mode[1] = 0; q_act[0] = 1'b0; q_act[1] = 1'b0;
        chk("rr_count", 32'(obs_log.size()), 32'd4);
        for (int i = 0; i < obs_log.size() && i < 4; i++)
            chk("rr_order", 32'(obs_log[i]), 32'(i % 2));

        // Reset during the RMW write-back cycle.
        saved = hmem[12];
        set_req(0, 1'b0, 1'b1, 32'h1000_0030, 32'hCAFE_F00D, 4'b0011);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_rmw_mw", 32'(obs_mw), 32'd0);
        chk("rst_rmw_w0", 32'(obs_w[0]), 32'd1);
        chk("rst_rmw_r0", obs_r[0], 32'd0);
        chk("rst_rmw_word", hmem[12], saved);
        tick();
        chk("rst_regrant_c0", 32'(obs_w[0]), 32'd1);
        tick();
        chk("rst_regrant_c1", 32'(obs_w[0]), 32'd0);

        // Empty byte enable, then read+write treated as a full write.
        set_req(0, 1'b0, 1'b1, 32'h1000_0014, 32'h7777_7777, 4'b0000);
        tick();
        chk("be0_wait", 32'(obs_w[0]), 32'd0);
        chk("be0_mw", 32'(obs_mw), 32'd0);
        set_req(1, 1'b1, 1'b1, 32'h1000_0018, 32'h1357_2468, 4'b1111);
        tick();
        chk("rw_wait", 32'(obs_w[1]), 32'd0);
        chk("rw_mw", 32'(obs_mw), 32'd1);
        chk("rw_wd", obs_wd, 32'h1357_2468);
        set_req(0, 1'b1, 1'b0, 32'h1000_0018, 32'h0, 4'b1111);
        tick(); tick();
        chk("rw_readback", obs_r[0], 32'h1357_2468);

        // Randomized traffic on both ports.
        mode[0] = 2; mode[1] = 2;
        for (int i = 0; i < 400; i++) tick();
        mode[0] = 0; mode[1] = 0;
        guard = 0;
        while ((q_act[0] || q_act[1] || m_busy) && guard < 10) begin
            tick(); guard++;
        end
        chk("drain_idle", 32'(q_act[0] | q_act[1] | m_busy), 32'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", hmem[i], ref_mem[i]);

        // Fixed priority: m0 keeps winning while it requests.
        f0_read = 1'b1; f1_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fp_f1_wait", 32'(f1_waitrequest), 32'd1);
            chk("fp_f0_wait", 32'(f0_waitrequest), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 1) chk("fp_f0_data", f0_readdata, 32'h40 ^ 32'hA5A5_0000);
            @(posedge clk); #1;
        end
        f0_read = 1'b0;
        @(negedge clk);
        chk("fp_f1_grant_c0", 32'(f1_waitrequest), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fp_f1_grant_c1", 32'(f1_waitrequest), 32'd0);
        chk("fp_f1_data", f1_readdata, 32'h80 ^ 32'hA5A5_0000);
        @(posedge clk); #1;
        f1_read = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
